// File: rtl/binary_morph_3x3.sv
// rtl/binary_morph_3x3.sv - 3x3 binary erosion/dilation over a line-shift-RAM fed window.
// Three-stage pipeline: input align, window shift + border sampling, result register.
module binary_morph_3x3 #(
  parameter int   IMG_WIDTH  = 640,
  parameter logic BORDER_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic mode,
  input  logic pre_frame_vsync,
  input  logic pre_frame_hsync,
  input  logic pre_frame_de,
  input  logic pre_img_bit,
  input  logic taps0x,
  input  logic taps1x,
  output logic post_frame_vsync,
  output logic post_frame_hsync,
  output logic post_frame_de,
  output logic post_img_bit
);

  localparam logic [9:0]  COL_MAX = (IMG_WIDTH > 1023) ? 10'd1023 : 10'(IMG_WIDTH);
  localparam logic [10:0] ROW_MAX = 11'h7FF;

  logic        s1_vs_q, s1_hs_q, s1_de_q, s1_bit_q;
  logic        s2_vs_q, s2_hs_q, s2_de_q, s2_edge_q;
  logic [2:0]  win0_q, win1_q, win2_q;
  logic [9:0]  col_q, col_d;
  logic [10:0] row_q, row_d;
  logic        vs_low_q, mode_q, frame_ok_q;
  logic        vs_rise;
  logic        img_d;

  // vs_low_q resets low so a release mid-frame is never mistaken for a frame start.
  assign vs_rise = pre_frame_vsync & vs_low_q;

  always_comb begin
    col_d = col_q;
    if (!s1_hs_q)
      col_d = '0;
    else if (s1_de_q && (col_q != COL_MAX))
      col_d = col_q + 10'd1;
  end

  always_comb begin
    row_d = row_q;
    if (!s1_vs_q)
      row_d = '0;
    else if (s2_hs_q && !s1_hs_q && (row_q != ROW_MAX))
      row_d = row_q + 11'd1;
  end

  always_comb begin
    img_d = 1'b0;
    if (s2_de_q) begin
      if (s2_edge_q || !frame_ok_q)
        img_d = BORDER_VAL;
      else if (mode_q)
        img_d = |{win0_q, win1_q, win2_q};
      else
        img_d = &{win0_q, win1_q, win2_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vs_q          <= 1'b0;
      s1_hs_q          <= 1'b0;
      s1_de_q          <= 1'b0;
      s1_bit_q         <= 1'b0;
      s2_vs_q          <= 1'b0;
      s2_hs_q          <= 1'b0;
      s2_de_q          <= 1'b0;
      s2_edge_q        <= 1'b1;
      win0_q           <= '0;
      win1_q           <= '0;
      win2_q           <= '0;
      col_q            <= '0;
      row_q            <= '0;
      vs_low_q         <= 1'b0;
      mode_q           <= 1'b0;
      frame_ok_q       <= 1'b0;
      post_frame_vsync <= 1'b0;
      post_frame_hsync <= 1'b0;
      post_frame_de    <= 1'b0;
      post_img_bit     <= 1'b0;
    end else begin
      s1_vs_q   <= pre_frame_vsync;
      s1_hs_q   <= pre_frame_hsync;
      s1_de_q   <= pre_frame_de;
      s1_bit_q  <= pre_img_bit;
      s2_vs_q   <= s1_vs_q;
      s2_hs_q   <= s1_hs_q;
      s2_de_q   <= s1_de_q;
      s2_edge_q <= (row_q < 11'd2) || (col_q < 10'd2);
      col_q     <= col_d;
      row_q     <= row_d;
      if (s1_de_q) begin
        win0_q <= {win0_q[1:0], taps1x};
        win1_q <= {win1_q[1:0], taps0x};
        win2_q <= {win2_q[1:0], s1_bit_q};
      end
      vs_low_q <= ~pre_frame_vsync;
      if (vs_rise) begin
        mode_q     <= mode;
        frame_ok_q <= 1'b1;
      end
      post_frame_vsync <= s2_vs_q;
      post_frame_hsync <= s2_hs_q;
      post_frame_de    <= s2_de_q;
      post_img_bit     <= img_d;
    end
  end

endmodule

// File: tb/tb_binary_morph_3x3.sv
// tb/tb_binary_morph_3x3.sv - randomized frames against a window-counting reference model.
module tb_binary_morph_3x3;

  localparam int   W  = 8;
  localparam int   H  = 8;
  localparam logic BV = 1'b0;

  logic clk = 1'b0;
  logic rst, mode, vs, hs, de, bit_i, t0, t1;
  logic post_vs, post_hs, post_de, post_bit;

  binary_morph_3x3 #(.IMG_WIDTH(W), .BORDER_VAL(BV)) dut (
    .clk              (clk),
    .rst              (rst),
    .mode             (mode),
    .pre_frame_vsync  (vs),
    .pre_frame_hsync  (hs),
    .pre_frame_de     (de),
    .pre_img_bit      (bit_i),
    .taps0x           (t0),
    .taps1x           (t1),
    .post_frame_vsync (post_vs),
    .post_frame_hsync (post_hs),
    .post_frame_de    (post_de),
    .post_img_bit     (post_bit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit         img [H][W];
  logic [3:0] dl [3];
  bit         frame_valid, frame_mode;
  logic       pend_t0, pend_t1;
  int         ones_seen, ones_contig;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output for input pixel (r,c) is the 3x3 neighbourhood rows r-2..r, cols c-2..c.
  function automatic logic ref_pixel(input int r, input int c);
    int ones;
    ones = 0;
    if (!frame_valid || r < 2 || c < 2) return BV;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        ones += int'(img[r-2+dr][c-2+dc]);
    return frame_mode ? (ones > 0) : (ones == 9);
  endfunction

  task automatic cyc(input logic v, input logic h, input logic d, input int r, input int c);
    logic e;
    t0    = pend_t0;
    t1    = pend_t1;
    vs    = v;
    hs    = h;
    de    = d;
    bit_i = d ? img[r][c] : ($urandom_range(0, 1) == 1);
    if (d) begin
      pend_t0 = (r >= 1) ? img[r-1][c] : 1'b0;
      pend_t1 = (r >= 2) ? img[r-2][c] : 1'b0;
    end
    e = d ? ref_pixel(r, c) : 1'b0;
    @(posedge clk);
    if (rst) begin
      dl[0] = '0; dl[1] = '0; dl[2] = '0;
    end else begin
      dl[2] = dl[1]; dl[1] = dl[0]; dl[0] = {v, h, d, e};
    end
    #1;
    check(rst ? "rst_out" : "vs_hs_de_bit", {post_vs, post_hs, post_de, post_bit}, dl[2]);
    if (post_de && post_bit) ones_seen++;
  endtask

  // kind: 0 all ones, 1 single pixel at (3,3), 2 random, 3 reuse previous image.
  task automatic run_frame(input int kind, input logic m, input bit gaps, input bit toggle, input int rst_row);
    if (kind != 3)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          img[r][c] = (kind == 0) ? 1'b1 : (kind == 1) ? (r == 3 && c == 3) : ($urandom_range(0, 3) != 0);
    mode = m;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0);
    frame_valid = 1'b1;
    frame_mode  = mode;
    ones_seen   = 0;
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
    for (int r = 0; r < H; r++) begin
      if (r == rst_row) begin
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        rst = 1'b0;
        frame_valid = 1'b0;
      end
      if (toggle && r == 4) mode = ~mode;
      for (int c = 0; c < W; c++) begin
        if (gaps && $urandom_range(0, 2) == 0) cyc(1'b1, 1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, r, c);
      end
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; vs = 1'b0; hs = 1'b0; de = 1'b0; bit_i = 1'b0;
    t0 = 1'b0; t1 = 1'b0; pend_t0 = 1'b0; pend_t1 = 1'b0;
    frame_valid = 1'b0; frame_mode = 1'b0; ones_seen = 0; ones_contig = 0;
    dl[0] = '0; dl[1] = '0; dl[2] = '0;
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
    rst = 1'b0;

    run_frame(0, 1'b0, 1'b0, 1'b0, -1);
    check("ones_all1_erode", ones_seen, 36);
    run_frame(1, 1'b1, 1'b0, 1'b0, -1);
    check("ones_single_dilate", ones_seen, 9);
    run_frame(1, 1'b0, 1'b0, 1'b0, -1);
    check("ones_single_erode", ones_seen, 0);

    run_frame(2, 1'b1, 1'b0, 1'b0, -1);
    ones_contig = ones_seen;
    run_frame(3, 1'b1, 1'b1, 1'b0, -1);
    check("gap_vs_contig", ones_seen, ones_contig);
    run_frame(2, 1'b0, 1'b1, 1'b0, -1);

    run_frame(2, 1'b0, 1'b0, 1'b1, -1);
    run_frame(2, mode, 1'b0, 1'b0, -1);

    run_frame(2, 1'b1, 1'b0, 1'b0, 4);
    run_frame(2, 1'b1, 1'b1, 1'b0, -1);
    run_frame(2, 1'b0, 1'b0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
